// File: rtl/xor_lane_gather.sv
// Serial-to-parallel gatherer: packs LANES consecutive WIDTH-bit beats into one
// registered group for the XOR fold stage. Short frames are zero-padded.
module xor_lane_gather #(
    parameter int WIDTH = 2,
    parameter int LANES = 4
) (
    input  logic                         CLK,
    input  logic                         RESETN,
    input  logic [WIDTH-1:0]             I,
    input  logic                         I_valid,
    input  logic                         I_last,
    output logic                         I_ready,
    output logic [LANES*WIDTH-1:0]       O,
    output logic [$clog2(LANES+1)-1:0]   O_count,
    output logic                         O_valid,
    input  logic                         O_ready
);

    localparam int CW = $clog2(LANES + 1);
    localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(LANES - 1);

    typedef enum logic [0:0] {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                   state_r, state_s;
    logic [IW-1:0]            idx_r, idx_s;
    logic [LANES*WIDTH-1:0]   data_r, data_s;
    logic [CW-1:0]            count_r, count_s;
    logic                     valid_r, valid_s;
    logic                     ready_s;

    // Next-state, lane writes and input-side ready.
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        data_s  = data_r;
        count_s = count_r;
        valid_s = valid_r;
        ready_s = 1'b1;
        case (state_r)
            FILL: begin
                ready_s = 1'b1;
                valid_s = 1'b0;
                if (I_valid) begin
                    // The first beat of a group wipes whatever the previous group left.
                    if (idx_r == {IW{1'b0}}) begin
                        data_s = '0;
                    end else begin
                        data_s = data_r;
                    end
                    data_s[int'(idx_r)*WIDTH +: WIDTH] = I;
                    count_s = CW'(idx_r) + CW'(1);
                    if (I_last || (idx_r == LAST_IDX)) begin
                        state_s = HOLD;
                        valid_s = 1'b1;
                        idx_s   = {IW{1'b0}};
                    end else begin
                        idx_s = idx_r + IW'(1);
                    end
                end else begin
                    idx_s = idx_r;
                end
            end
            HOLD: begin
                ready_s = O_ready;
                if (O_ready) begin
                    if (I_valid) begin
                        data_s            = '0;
                        data_s[WIDTH-1:0] = I;
                        count_s           = CW'(1);
                        if (I_last || (LANES == 1)) begin
                            state_s = HOLD;
                            valid_s = 1'b1;
                            idx_s   = {IW{1'b0}};
                        end else begin
                            state_s = FILL;
                            valid_s = 1'b0;
                            idx_s   = IW'(1);
                        end
                    end else begin
                        state_s = FILL;
                        valid_s = 1'b0;
                        data_s  = '0;
                        count_s = {CW{1'b0}};
                        idx_s   = {IW{1'b0}};
                    end
                end else begin
                    valid_s = 1'b1;
                end
            end
            default: begin
                state_s = FILL;
                idx_s   = {IW{1'b0}};
                data_s  = '0;
                count_s = {CW{1'b0}};
                valid_s = 1'b0;
                ready_s = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state_r <= FILL;
            idx_r   <= {IW{1'b0}};
            data_r  <= '0;
            count_r <= {CW{1'b0}};
            valid_r <= 1'b0;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            data_r  <= data_s;
            count_r <= count_s;
            valid_r <= valid_s;
        end
    end

    assign I_ready = ready_s;
    assign O       = data_r;
    assign O_count = count_r;
    assign O_valid = valid_r;

endmodule

// File: tb/tb_xor_lane_gather.sv
// Randomized + directed bench for xor_lane_gather with a frame-level reference
// model feeding a scoreboard; a separate monitor checks every transferred group.
module tb_xor_lane_gather;

    localparam int W  = 2;
    localparam int L  = 4;
    localparam int CW = 3;

    logic          CLK = 1'b0;
    logic          RESETN;
    logic [W-1:0]  I;
    logic          I_valid;
    logic          I_last;
    logic          I_ready;
    logic [L*W-1:0] O;
    logic [CW-1:0] O_count;
    logic          O_valid;
    logic          O_ready;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [L*W-1:0] data;
        logic [CW-1:0]  cnt;
    } grp_t;

    grp_t       exp_q[$];
    logic [W-1:0] cur_q[$];

    logic stream_on = 1'b0;
    int   pulses    = 0;
    int   drops     = 0;
    logic rand_on   = 1'b0;

    xor_lane_gather #(.WIDTH(W), .LANES(L)) dut (
        .CLK     (CLK),
        .RESETN  (RESETN),
        .I       (I),
        .I_valid (I_valid),
        .I_last  (I_last),
        .I_ready (I_ready),
        .O       (O),
        .O_count (O_count),
        .O_valid (O_valid),
        .O_ready (O_ready)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] fold(input logic [L*W-1:0] v);
        logic [W-1:0] f = '0;
        for (int k = 0; k < L; k++) f ^= v[k*W +: W];
        return f;
    endfunction

    // Reference model: accepted beats are grouped L at a time or cut short by I_last.
    always @(negedge CLK) begin
        if (!RESETN) begin
            cur_q.delete();
            exp_q.delete();
        end else if (I_valid && I_ready) begin
            cur_q.push_back(I);
            if (cur_q.size() == L || I_last) begin
                grp_t g;
                g.data = '0;
                for (int k = 0; k < cur_q.size(); k++) g.data[k*W +: W] = cur_q[k];
                g.cnt = CW'(cur_q.size());
                exp_q.push_back(g);
                cur_q.delete();
            end
        end
    end

    // Monitor: every transferred group must match the oldest expected one.
    always @(negedge CLK) begin
        if (RESETN && O_valid && O_ready) begin
            if (exp_q.size() == 0) begin
                check("scb_unexpected_group", 32'd1, 32'd0);
            end else begin
                grp_t g;
                g = exp_q.pop_front();
                check("scb_data", O, g.data);
                check("scb_count", O_count, g.cnt);
            end
        end
    end

    always @(negedge CLK) begin
        if (stream_on) begin
            if (O_valid) pulses++;
            if (!I_ready) drops++;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [W-1:0] d, input logic l);
        int waited = 0;
        I = d;
        I_last = l;
        I_valid = 1'b1;
        @(negedge CLK);
        while (!I_ready && waited < 200) begin
            waited++;
            @(negedge CLK);
        end
        if (!I_ready) check("send_timeout", 32'd0, 32'd1);
        tick();
        I_valid = 1'b0;
        I_last = 1'b0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] b[4];
        RESETN = 1'b0; I = '0; I_valid = 1'b0; I_last = 1'b0; O_ready = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        @(negedge CLK);
        check("rst_valid", O_valid, 0);
        check("rst_data", O, 0);
        check("rst_count", O_count, 0);
        check("rst_ready", I_ready, 1);
        tick();
        RESETN = 1'b1;
        O_ready = 1'b1;
        tick();

        // Full group 1,2,3,0
        send(2'd1, 1'b0); send(2'd2, 1'b0); send(2'd3, 1'b0); send(2'd0, 1'b0);
        @(negedge CLK);
        check("full_valid", O_valid, 1);
        check("full_data", O, 8'h39);
        check("full_count", O_count, 4);
        check("full_fold", fold(O), 0);
        tick();
        @(negedge CLK);
        check("full_drained", O_valid, 0);
        tick();

        // Short frame 3,2(last)
        send(2'd3, 1'b0); send(2'd2, 1'b1);
        @(negedge CLK);
        check("short_valid", O_valid, 1);
        check("short_data", O, 8'h0B);
        check("short_count", O_count, 2);
        check("short_pad", O[7:4], 0);
        check("short_fold", fold(O), 2'd1);
        tick();

        // Backpressure with a held beat
        O_ready = 1'b0;
        send(2'd1, 1'b0); send(2'd1, 1'b0); send(2'd1, 1'b0); send(2'd1, 1'b0);
        I = 2'd2; I_last = 1'b0; I_valid = 1'b1;
        repeat (5) begin
            @(negedge CLK);
            check("bp_valid", O_valid, 1);
            check("bp_data", O, 8'h55);
            check("bp_count", O_count, 4);
            check("bp_ready", I_ready, 0);
            tick();
        end
        O_ready = 1'b1;
        @(negedge CLK);
        check("bp_release_ready", I_ready, 1);
        tick();
        I_valid = 1'b0;
        @(negedge CLK);
        check("bp_next_valid", O_valid, 0);
        check("bp_next_data", O, 8'h02);
        check("bp_next_count", O_count, 1);
        tick();
        send(2'd1, 1'b1);
        tick(); tick();

        // Streaming 12 beats
        stream_on = 1'b1;
        for (int i = 0; i < 12; i++) send(W'($urandom_range(0, 3)), 1'b0);
        tick();
        stream_on = 1'b0;
        check("stream_pulses", pulses, 3);
        check("stream_ready_drops", drops, 0);
        tick();

        // Reset mid-group
        send(2'd3, 1'b0); send(2'd3, 1'b0);
        RESETN = 1'b0;
        tick();
        RESETN = 1'b1;
        @(negedge CLK);
        check("midrst_valid", O_valid, 0);
        check("midrst_data", O, 0);
        check("midrst_count", O_count, 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            b[i] = W'($urandom_range(0, 3));
            send(b[i], 1'b0);
        end
        @(negedge CLK);
        check("midrst_clean", O, {b[3], b[2], b[1], b[0]});
        check("midrst_clean_count", O_count, 4);
        tick();

        // Single-beat frame accepted while holding
        O_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(W'($urandom_range(0, 3)), 1'b0);
        I = 2'd2; I_last = 1'b1; I_valid = 1'b1; O_ready = 1'b1;
        tick();
        I_valid = 1'b0; I_last = 1'b0;
        @(negedge CLK);
        check("single_valid", O_valid, 1);
        check("single_data", O, 8'h02);
        check("single_count", O_count, 1);
        tick(); tick();

        // Random traffic with random backpressure
        rand_on = 1'b1;
        fork
            begin
                while (rand_on) begin
                    @(posedge CLK);
                    #1;
                    O_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join_none
        for (int i = 0; i < 300; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            send(W'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0));
        end
        send(W'($urandom_range(0, 3)), 1'b1);
        rand_on = 1'b0;
        repeat (2) @(posedge CLK);
        #2;
        O_ready = 1'b1;
        repeat (10) tick();
        check("drain_expected_empty", exp_q.size(), 0);
        check("drain_partial_empty", cur_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
